store_buffer: RTL
=================

Name: store_buffer

Overview:
- Controller for the memory stage's write buffer: a circular queue of wbuffer_entry_t (memory_pkg) sitting between the memory stage and the D-cache.
- Accepts speculative stores (wreq) and marks them committed in order (creq).
- Drains committed entries to the D-cache one at a time over a valid/ready handshake.
- Forwards buffered bytes to loads (rreq/rresp); discards uncommitted entries on flush.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), index width; count width is PTR_W+1.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- wreq  in  wbuffer_wreq_t  store enqueue; wreq.valid is the request
- wreq_ready  out  1  enqueue accepted this cycle
- creq  in  wbuffer_creq_t  commit oldest uncommitted entry when creq.valid
- flush  in  1  discard all uncommitted entries
- rreq  in  wbuffer_rreq_t  load forwarding lookup address
- rresp  out  wbuffer_rresp_t  per-byte forward valid and data (combinational)
- dreq_valid  out  1  D-cache write request
- dreq_addr  out  32  write address
- dreq_msize  out  msize_t  write size
- dreq_strobe  out  strobe_t  byte strobe
- dreq_data  out  u8[7:0]  write data
- dreq_ready  in  1  D-cache accepts/completes the write
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- drained  out  1  no committed entries remain (fence support)

Behaviour:
- State: entry array; pointers head (oldest), cptr (oldest uncommitted), tail (next free); counters count and ccount (committed).
- Reset (resetn low, asynchronous): all pointers and counters 0, all entry valid bits 0, FSM in IDLE. Outputs: dreq_valid 0, full 0, empty 1, drained 1, rresp.valid 0. An in-flight drain is abandoned.
- Enqueue:
  - wreq_ready = !full && !flush.
  - When wreq.valid && wreq_ready, the entry is written at tail as uncommitted, tail++, count++.
  - wreq with valid=0 is ignored.
- Commit:
  - When creq.valid && (count - ccount) > 0, using values before this cycle: ccount++, cptr++.
  - An entry enqueued this cycle cannot be committed this cycle.
  - creq with no uncommitted entry is ignored; the bench flags it as an error.
- Flush:
  - Applied after any same-cycle commit.
  - tail = cptr, count = ccount, and the discarded entries' valid bits are cleared.
  - Committed entries and the in-flight drain are unaffected.
- Drain FSM:
  - IDLE: if ccount > 0, go to BUSY next cycle. dreq_* come from the entry at head, registered at the transition.
  - BUSY: dreq_valid = 1; dreq_* stay stable until dreq_ready. On dreq_ready, head++, count--, ccount--, entry valid cleared, return to IDLE.
  - Drain rate is one entry per 2 cycles minimum.
- Simultaneous events:
  - Enqueue, commit and drain completion may occur in the same cycle; counters apply the net delta (count += enq - deq; ccount += cmt - deq).
  - full is evaluated before the cycle, so there is no enqueue-on-dequeue bypass.
- Pointer wrap: modulo DEPTH via PTR_W-bit natural overflow.
- Forwarding (combinational):
  - An entry matches when valid && entry.addr[31:3] == rreq.addr[31:3].
  - This includes uncommitted entries and the entry being drained.
  - Per byte i, the youngest matching entry with strobe[i] set supplies data[i] and sets rresp.valid[i].
  - Unmatched bytes: valid 0, data 0.
  - Age order: walk from head to tail-1.
- drained = (ccount == 0) && FSM in IDLE.

Decomposition:
- memory_pkg gains:
  - sb_state_t enum (IDLE, BUSY)
  - wbuffer_dreq_t struct (valid, addr, msize, strobe, data)
  - SB_DEPTH default constant
- Existing wbuffer_* types are reused unchanged.
- One sub-module, sb_forward: the combinational per-byte youngest-match merge, taking the entry array plus head/count and returning wbuffer_rresp_t.

Test Plan:
- Basic flow: enqueue addr 0x80000010, strobe 0x0F, data 0x11223344, then creq the next cycle.
  - Required: dreq_valid rises 2 cycles after the commit with the same fields.
  - With dreq_ready held 3 cycles later: empty=1, drained=1.
- Fill: enqueue 8 stores without commit.
  - Required: full=1, wreq_ready=0; a 9th wreq is not accepted; count stays 8.
- Forwarding: store A at 0x100, strobe 0xFF, data 0x01 in every byte; then younger store B at 0x104, strobe 0xF0, data 0x02 in every byte; rreq 0x100.
  - Required: rresp.valid = 0xFF; bytes 7:4 = 0x02, bytes 3:0 = 0x01.
  - rreq 0x108: rresp.valid = 0x00.
- Flush: 5 entries, 2 committed, flush with a simultaneous creq.
  - Required: count=3, ccount=3, forwarding no longer hits the flushed addresses.
  - The drain continues for the 3 remaining entries.
- Back-pressure and wrap: 20 stores with commit each cycle, dreq_ready random at 30%.
  - Required: writes reach the D-cache in program order with exact fields across pointer wrap.
  - dreq_* stay stable while dreq_ready is low.
- Reset mid-drain: resetn low while in BUSY.
  - Required: dreq_valid=0 immediately (asynchronous); after release empty=1 and a new store flows normally.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared memory-stage types: write-buffer entries and requests, D-cache write
// request, and the store buffer drain state.
package memory_pkg;

  typedef logic [7:0] u8;
  typedef logic [7:0] strobe_t;

  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2,
    MSIZE_D = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      msize;
    strobe_t     strobe;
    u8 [7:0]     data;
  } wbuffer_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      msize;
    strobe_t     strobe;
    u8 [7:0]     data;
  } wbuffer_wreq_t;

  typedef struct packed {
    logic valid;
  } wbuffer_creq_t;

  typedef struct packed {
    logic [31:0] addr;
  } wbuffer_rreq_t;

  typedef struct packed {
    strobe_t valid;
    u8 [7:0] data;
  } wbuffer_rresp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sb_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      msize;
    strobe_t     strobe;
    u8 [7:0]     data;
  } wbuffer_dreq_t;

  localparam int SB_DEPTH = 8;

endpackage

// File: rtl/sb_forward.sv
// Load forwarding merge: per byte, the youngest buffered store to the same
// doubleword with that strobe bit set supplies the byte.
module sb_forward
  import memory_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  wbuffer_entry_t [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]           head,
  input  logic [PTR_W:0]             count,
  input  wbuffer_rreq_t              rreq,
  output wbuffer_rresp_t             rresp
);

  wbuffer_entry_t e;
  logic           unused_bits;

  // Byte offset and size only matter to the matching entries' strobes.
  assign unused_bits = ^{rreq.addr[2:0], entries};

  // Walking oldest to youngest lets later matches overwrite earlier ones.
  always_comb begin
    rresp = '0;
    e     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      e = entries[head + PTR_W'(k)];
      if (((PTR_W+1)'(k) < count) && e.valid && (e.addr[31:3] == rreq.addr[31:3])) begin
        for (int b = 0; b < 8; b++) begin
          if (e.strobe[b]) begin
            rresp.valid[b] = 1'b1;
            rresp.data[b]  = e.data[b];
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Write buffer controller: speculative enqueue, in-order commit, flush of
// uncommitted stores, one-at-a-time drain to the D-cache, load forwarding.
module store_buffer
  import memory_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           resetn,
  input  wbuffer_wreq_t  wreq,
  output logic           wreq_ready,
  input  wbuffer_creq_t  creq,
  input  logic           flush,
  input  wbuffer_rreq_t  rreq,
  output wbuffer_rresp_t rresp,
  output logic           dreq_valid,
  output logic [31:0]    dreq_addr,
  output msize_t         dreq_msize,
  output strobe_t        dreq_strobe,
  output u8 [7:0]        dreq_data,
  input  logic           dreq_ready,
  output logic           full,
  output logic           empty,
  output logic           drained
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head, cptr, tail, cptr_c, rel;
  logic [PTR_W:0]   count, ccount, ccount_n, uncmt_c;
  logic [DEPTH-1:0] ent_valid, discard;
  logic [31:0]      ent_addr   [DEPTH];
  msize_t           ent_msize  [DEPTH];
  strobe_t          ent_strobe [DEPTH];
  u8 [7:0]          ent_data   [DEPTH];
  wbuffer_entry_t [DEPTH-1:0] entries;
  sb_state_t        state, state_n;
  logic             enq, cmt, deq, load;

  assign full       = (count == DEPTH_CNT);
  assign empty      = (count == '0);
  assign wreq_ready = !full && !flush;
  assign enq        = wreq.valid && wreq_ready;
  assign cmt        = creq.valid && (count != ccount);
  assign deq        = (state == BUSY) && dreq_ready;
  assign dreq_valid = (state == BUSY);
  assign drained    = (ccount == '0) && (state == IDLE);

  // Flush acts after this cycle's commit, so it rewinds to the advanced cptr.
  assign cptr_c   = cptr + PTR_W'(cmt);
  assign uncmt_c  = count - ccount - (PTR_W+1)'(cmt);
  assign ccount_n = ccount + (PTR_W+1)'(cmt) - (PTR_W+1)'(deq);

  always_comb begin
    discard = '0;
    rel     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel        = PTR_W'(i) - cptr_c;
      discard[i] = flush && ({1'b0, rel} < uncmt_c);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head      <= '0;
      cptr      <= '0;
      tail      <= '0;
      count     <= '0;
      ccount    <= '0;
      ent_valid <= '0;
    end else begin
      head   <= head + PTR_W'(deq);
      cptr   <= cptr_c;
      ccount <= ccount_n;
      if (flush) begin
        tail  <= cptr_c;
        count <= ccount_n;
      end else begin
        tail  <= tail + PTR_W'(enq);
        count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
      end
      if (deq) ent_valid[head] <= 1'b0;
      if (enq) ent_valid[tail] <= 1'b1;
      ent_valid <= (deq || enq) ? ent_valid_upd() : (ent_valid & ~discard);
    end
  end

  function automatic logic [DEPTH-1:0] ent_valid_upd();
    logic [DEPTH-1:0] v;
    v = ent_valid & ~discard;
    if (deq) v[head] = 1'b0;
    if (enq) v[tail] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // The head fields are captured as the drain FSM leaves IDLE.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      IDLE: if (ccount != '0) begin
        state_n = BUSY;
        load    = 1'b1;
      end
      BUSY: if (dreq_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail]   <= wreq.addr;
      ent_msize[tail]  <= wreq.msize;
      ent_strobe[tail] <= wreq.strobe;
      ent_data[tail]   <= wreq.data;
    end
    if (load) begin
      dreq_addr   <= ent_addr[head];
      dreq_msize  <= ent_msize[head];
      dreq_strobe <= ent_strobe[head];
      dreq_data   <= ent_data[head];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i].valid  = ent_valid[i];
      entries[i].addr   = ent_addr[i];
      entries[i].msize  = ent_msize[i];
      entries[i].strobe = ent_strobe[i];
      entries[i].data   = ent_data[i];
    end
  end

  sb_forward #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_forward (
    .entries(entries),
    .head   (head),
    .count  (count),
    .rreq   (rreq),
    .rresp  (rresp)
  );

endmodule
